// File: rtl/cipher_cmd_ctrl_pkg.sv
// Shared opcodes, reply codes, block geometry and FSM state encoding for the
// cipher command sequencer.
package cipher_ctrl_pkg;

  localparam logic [7:0] OPC_KEY = 8'h4B;
  localparam logic [7:0] OPC_ENC = 8'h45;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam int BLOCK_BYTES = 12;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_KEY   = 3'd1,
    ST_RX_DATA  = 3'd2,
    ST_SEND_BLK = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_TX_BLK   = 3'd5,
    ST_TX_BYTE  = 3'd6
  } state_t;

endpackage

// File: rtl/cipher_cmd_ctrl_if.sv
// Byte streams (UART RX/TX) and block streams (cipher in/out) of the sequencer.
// Every channel: a transfer happens on a rising edge where tvalid and tready are
// both high; once tvalid is raised, tvalid and tdata stay unchanged until that edge.
interface cipher_cmd_ctrl_if;
  import cipher_ctrl_pkg::*;

  logic [7:0]         s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [BLOCK_W-1:0] cipher_tdata;
  logic               cipher_tvalid;
  logic               cipher_tready;
  logic [BLOCK_W-1:0] result_tdata;
  logic               result_tvalid;
  logic               result_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, input  m_axis_tready,
    output cipher_tdata, cipher_tvalid, input  cipher_tready,
    input  result_tdata, result_tvalid, output result_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, output m_axis_tready,
    input  cipher_tdata, cipher_tvalid, output cipher_tready,
    output result_tdata, result_tvalid, input  result_tready
  );

endinterface

// File: rtl/cipher_cmd_ctrl_block_shifter.sv
// 96-bit shift register shared by byte deserialise (shift in at LSB) and
// serialise (byte out from MSB), with a 0..11 byte counter and last flag.
module block_shifter
  import cipher_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_shift_in,
  input  logic               i_shift_out,
  input  logic [BLOCK_W-1:0] i_load_data,
  input  logic [7:0]         i_byte,
  output logic [BLOCK_W-1:0] o_data,
  output logic [7:0]         o_byte,
  output logic               o_last
);

  logic [BLOCK_W-1:0] r_data;
  logic [3:0]         r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == 4'(BLOCK_BYTES - 1));

  // The counter wraps after the last byte so the next phase starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift_in || i_shift_out) begin
      r_data <= {r_data[BLOCK_W-9:0], (i_shift_in ? i_byte : 8'h00)};
      r_cnt  <= w_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

  assign o_data = r_data;
  assign o_byte = r_data[BLOCK_W-1 -: 8];
  assign o_last = w_last;

endmodule

// File: rtl/cipher_cmd_ctrl.sv
// Command sequencer between UART byte streams and the 96-bit cipher: loads the key
// ('K'), runs one block ('E'). Optional inter-byte timeout: macro CMD_TIMEOUT_EN.
module cipher_cmd_ctrl
  import cipher_ctrl_pkg::*;
#(
  parameter logic [BLOCK_W-1:0] KEY_INIT       = 96'h0123456789ABCDEF11112222,
  parameter int                 TIMEOUT_CYCLES = 10_000_000
)(
  input  logic                clk,
  input  logic                rst_n,
  cipher_cmd_ctrl_if.slave    io_bus,
  output logic [BLOCK_W-1:0]  key,
  output logic                busy,
  output state_t              o_dbg_state
);

  state_t             r_state, w_nxt;
  logic [BLOCK_W-1:0] r_key, w_sh_data;
  logic [7:0]         r_reply, w_reply, w_tx_byte;
  logic               w_accept, w_timeout, w_last;
  logic               w_sh_clr, w_sh_in, w_sh_out, w_sh_load, w_key_we, w_reply_we;

  assign w_accept = io_bus.s_axis_tvalid && io_bus.s_axis_tready;

  block_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_sh_clr),
    .i_load      (w_sh_load),
    .i_shift_in  (w_sh_in),
    .i_shift_out (w_sh_out),
    .i_load_data (io_bus.result_tdata),
    .i_byte      (io_bus.s_axis_tdata),
    .o_data      (w_sh_data),
    .o_byte      (w_tx_byte),
    .o_last      (w_last)
  );

`ifdef CMD_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        w_in_rx;

  assign w_in_rx = (r_state == ST_RX_KEY) || (r_state == ST_RX_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_tmo_cnt <= '0;
    else if (!w_in_rx || w_accept) r_tmo_cnt <= '0;
    else                           r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_timeout = w_in_rx && !w_accept && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  // Constant false: without the timeout the RX states wait indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= KEY_INIT;
      r_reply <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_key_we)   r_key   <= {w_sh_data[BLOCK_W-9:0], io_bus.s_axis_tdata};
      if (w_reply_we) r_reply <= w_reply;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_sh_clr   = 1'b0;
    w_sh_in    = 1'b0;
    w_sh_out   = 1'b0;
    w_sh_load  = 1'b0;
    w_key_we   = 1'b0;
    w_reply_we = 1'b0;
    w_reply    = RSP_ERR;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (io_bus.s_axis_tdata == OPC_KEY)      w_nxt = ST_RX_KEY;
          else if (io_bus.s_axis_tdata == OPC_ENC) w_nxt = ST_RX_DATA;
          else begin
            w_nxt      = ST_TX_BYTE;
            w_reply_we = 1'b1;
            w_reply    = RSP_ERR;
          end
        end
      end
      ST_RX_KEY, ST_RX_DATA: begin
        if (w_accept) begin
          w_sh_in = 1'b1;
          if (w_last && (r_state == ST_RX_KEY)) begin
            w_key_we   = 1'b1;
            w_reply_we = 1'b1;
            w_reply    = RSP_ACK;
            w_nxt      = ST_TX_BYTE;
          end else if (w_last) begin
            w_nxt = ST_SEND_BLK;
          end
        end else if (w_timeout) begin
          w_sh_clr   = 1'b1;
          w_reply_we = 1'b1;
          w_reply    = RSP_NAK;
          w_nxt      = ST_TX_BYTE;
        end
      end
      ST_SEND_BLK: if (io_bus.cipher_tready) w_nxt = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (io_bus.result_tvalid) begin
          w_sh_load = 1'b1;
          w_nxt     = ST_TX_BLK;
        end
      end
      ST_TX_BLK: begin
        if (io_bus.m_axis_tready) begin
          w_sh_out = 1'b1;
          if (w_last) w_nxt = ST_IDLE;
        end
      end
      ST_TX_BYTE: if (io_bus.m_axis_tready) w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  assign io_bus.s_axis_tready = (r_state == ST_IDLE) || (r_state == ST_RX_KEY) ||
                                (r_state == ST_RX_DATA);
  assign io_bus.m_axis_tvalid = (r_state == ST_TX_BLK) || (r_state == ST_TX_BYTE);
  assign io_bus.m_axis_tdata  = (r_state == ST_TX_BYTE) ? r_reply : w_tx_byte;
  assign io_bus.cipher_tvalid = (r_state == ST_SEND_BLK);
  assign io_bus.cipher_tdata  = w_sh_data;
  assign io_bus.result_tready = (r_state == ST_WAIT_RES);

  assign key         = r_key;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cipher_cmd_ctrl.sv
// Self-checking bench for cipher_cmd_ctrl: frame table plus stall, reset and
// (with CMD_TIMEOUT_EN) timeout sequences against an inverting cipher stub.
module tb_cipher_cmd_ctrl;
  import cipher_ctrl_pkg::*;

  localparam logic [95:0] KEY_INIT = 96'h0123456789ABCDEF11112222;
  localparam int          TMO      = 100;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] key;
  logic        busy;
  state_t      dbg_state;

  always #5 clk = ~clk;

  cipher_cmd_ctrl_if ifc();

  cipher_cmd_ctrl #(.KEY_INIT(KEY_INIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (ifc.slave),
    .key         (key),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [95:0] cip_q[$];
  bit         tx_toggle = 1'b0;
  bit         cip_rdy_en = 1'b1;

  typedef struct {
    logic [7:0]  op;
    int          npay;
    logic [95:0] pay;
    bit          chk_cip;
    logic [95:0] exp_cip;
    int          nrep;
    logic [95:0] exp_rep;
    logic [95:0] exp_key;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // TX sink: decides tready for the coming edge and logs the byte taken there.
  always @(negedge clk) begin
    ifc.m_axis_tready = tx_toggle ? ~ifc.m_axis_tready : 1'b1;
    if (ifc.m_axis_tvalid && ifc.m_axis_tready) got_q.push_back(ifc.m_axis_tdata);
  end

  // Cipher stub: result is the inverted block, offered 5 cycles after acceptance.
  int          res_cnt = 0;
  bit          res_hs = 1'b0;
  logic [95:0] res_blk;
  always @(negedge clk) begin
    if (res_hs) begin
      ifc.result_tvalid = 1'b0;
      res_hs = 1'b0;
    end
    ifc.cipher_tready = cip_rdy_en;
    if (ifc.cipher_tvalid && ifc.cipher_tready) begin
      cip_q.push_back(ifc.cipher_tdata);
      res_blk = ~ifc.cipher_tdata;
      res_cnt = 5;
    end else if (res_cnt > 0) begin
      res_cnt--;
      if (res_cnt == 0) begin
        ifc.result_tdata  = res_blk;
        ifc.result_tvalid = 1'b1;
      end
    end
    if (ifc.result_tvalid && ifc.result_tready) res_hs = 1'b1;
  end

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ifc.s_axis_tdata  = b;
    ifc.s_axis_tvalid = 1'b1;
    while (!ifc.s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL s_axis handshake timeout actual=stalled required=accepted");
    end
    @(negedge clk);
    ifc.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_replies(input int nrep, input string nm);
    int n = 0;
    logic [7:0] e, g;
    while (got_q.size() < nrep && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, " reply count"}, 96'(got_q.size()), 96'(nrep));
    for (int i = 0; i < nrep; i++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      chk({nm, " reply byte"}, {88'h0, g}, {88'h0, e});
    end
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    got_q.delete();
    cip_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.nrep; i++) exp_q.push_back(v.exp_rep[95-8*i -: 8]);
    send_byte(v.op);
    for (int i = 0; i < v.npay; i++) send_byte(v.pay[95-8*i -: 8]);
    wait_replies(v.nrep, nm);
    if (v.chk_cip) chk({nm, " cipher block"}, (cip_q.size() > 0) ? cip_q[0] : 96'hx, v.exp_cip);
    chk({nm, " key"}, key, v.exp_key);
    chk({nm, " busy after reply"}, {95'h0, busy}, 96'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [95:0] blk;
    int n;

    vecs[0] = '{OPC_ENC, 12, 96'h000102030405060708090A0B, 1'b1, 96'h000102030405060708090A0B,
                12, 96'hFFFEFDFCFBFAF9F8F7F6F5F4, KEY_INIT};
    vecs[1] = '{OPC_KEY, 12, 96'h1112131415161718191A1B1C, 1'b0, 96'h0,
                1, {8'h06, 88'h0}, 96'h1112131415161718191A1B1C};
    vecs[2] = '{8'h5A, 0, 96'h0, 1'b0, 96'h0,
                1, {8'h3F, 88'h0}, 96'h1112131415161718191A1B1C};
    vecs[3] = '{OPC_ENC, 12, 96'hA55A00FF123456789ABCDEF0, 1'b1, 96'hA55A00FF123456789ABCDEF0,
                12, 96'h5AA5FF00EDCBA9876543210F, 96'h1112131415161718191A1B1C};
    vecs[4] = '{OPC_KEY, 12, 96'hCAFEBABEDEADBEEF00C0FFEE, 1'b0, 96'h0,
                1, {8'h06, 88'h0}, 96'hCAFEBABEDEADBEEF00C0FFEE};
    vecs[5] = '{OPC_ENC, 12, 96'h0, 1'b1, 96'h0,
                12, 96'hFFFFFFFFFFFFFFFFFFFFFFFF, 96'hCAFEBABEDEADBEEF00C0FFEE};

    ifc.s_axis_tdata  = 8'h00;
    ifc.s_axis_tvalid = 1'b0;
    ifc.m_axis_tready = 1'b1;
    ifc.cipher_tready = 1'b1;
    ifc.result_tdata  = '0;
    ifc.result_tvalid = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset s_axis_tready", {95'h0, ifc.s_axis_tready}, 96'h1);
    chk("reset m_axis_tvalid", {95'h0, ifc.m_axis_tvalid}, 96'h0);
    chk("reset cipher_tvalid", {95'h0, ifc.cipher_tvalid}, 96'h0);
    chk("reset result_tready", {95'h0, ifc.result_tready}, 96'h0);
    chk("reset busy", {95'h0, busy}, 96'h0);
    chk("reset key", key, KEY_INIT);
    chk("reset cipher_tdata", ifc.cipher_tdata, 96'h0);
    chk("reset state", 96'(dbg_state), 96'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // TX backpressure toggling and a cipher stalled for 20 cycles.
    blk = 96'hF0E1D2C3B4A5968778695A4B;
    got_q.delete();
    cip_q.delete();
    tx_toggle  = 1'b1;
    cip_rdy_en = 1'b0;
    send_byte(OPC_ENC);
    for (int i = 0; i < 12; i++) send_byte(blk[95-8*i -: 8]);
    for (int i = 0; i < 20; i++) begin
      chk("stall cipher_tvalid", {95'h0, ifc.cipher_tvalid}, 96'h1);
      chk("stall cipher_tdata", ifc.cipher_tdata, blk);
      chk("stall s_axis_tready", {95'h0, ifc.s_axis_tready}, 96'h0);
      @(negedge clk);
    end
    cip_rdy_en = 1'b1;
    for (int i = 0; i < 12; i++) exp_q.push_back(~blk[95-8*i -: 8]);
    wait_replies(12, "stall");
    tx_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an 'E' payload.
    got_q.delete();
    send_byte(OPC_ENC);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i));
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {95'h0, busy}, 96'h0);
    chk("midreset s_axis_tready", {95'h0, ifc.s_axis_tready}, 96'h1);
    chk("midreset m_axis_tvalid", {95'h0, ifc.m_axis_tvalid}, 96'h0);
    chk("midreset cipher_tvalid", {95'h0, ifc.cipher_tvalid}, 96'h0);
    chk("midreset cipher_tdata", ifc.cipher_tdata, 96'h0);
    chk("midreset key", key, KEY_INIT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec('{OPC_ENC, 12, 96'h0123456789ABCDEF00112233, 1'b1, 96'h0123456789ABCDEF00112233,
              12, 96'hFEDCBA9876543210FFEEDDCC, KEY_INIT}, "post-reset");

`ifdef CMD_TIMEOUT_EN
    // 'K' with three bytes then silence: NAK after the idle budget, key untouched.
    got_q.delete();
    send_byte(OPC_KEY);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    n = 0;
    while (got_q.size() < 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout latency in range", {95'h0, (n >= 95 && n <= 105)}, 96'h1);
    exp_q.push_back(RSP_NAK);
    wait_replies(1, "timeout");
    chk("timeout key", key, KEY_INIT);
    chk("timeout busy", {95'h0, busy}, 96'h0);
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
